// File: rtl/l2_request_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : l2_request_arbiter_pkg                                   |
// | Description : Shared types for the L2 request arbiter: request packet, |
// |               core id type, core count and a small mask helper.        |
// | Options     : L2_ARB_PERF_COUNTERS_EN (see l2_request_arbiter)         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package l2_request_arbiter_pkg;

  localparam int NUM_CORES        = `NUM_CORES;
  localparam int CORE_ID_WIDTH    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PERF_COUNT_WIDTH = 32;

  typedef logic [CORE_ID_WIDTH-1:0] core_id_t;

  typedef enum logic [1:0] {
    L2_OP_LOAD  = 2'd0,
    L2_OP_STORE = 2'd1,
    L2_OP_FLUSH = 2'd2,
    L2_OP_INVAL = 2'd3
  } l2_op_t;

  typedef struct packed {
    logic        valid;
    l2_op_t      op;
    logic [31:0] address;
    logic [31:0] data;
  } l2req_packet_t;

  // True when two or more bits of the mask are set.
  function automatic logic multi_hot(input logic [15:0] mask);
    return (mask & (mask - 16'd1)) != 16'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l2_request_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : l2_request_arbiter_if                                    |
// | Description : Bundle of core request inputs, per-core ready, the       |
// |               registered winning packet and the L2 stall input.        |
// | Options     : L2_ARB_PERF_COUNTERS_EN adds performance counter outputs |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+

interface l2_request_arbiter_if
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES,
  parameter int ID_WIDTH       = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) ();

  l2req_packet_t [NUM_REQUESTERS-1:0] l2i_request;
  logic          [NUM_REQUESTERS-1:0] l2_ready;
  l2req_packet_t                      arb_request;
  logic          [ID_WIDTH-1:0]       arb_core_id;
  logic                               l2_stall;
`ifdef L2_ARB_PERF_COUNTERS_EN
  logic [NUM_REQUESTERS-1:0][PERF_COUNT_WIDTH-1:0] perf_grant_count;
  logic [PERF_COUNT_WIDTH-1:0]                     perf_conflict_count;

  modport master (
    output l2i_request, l2_stall,
    input  l2_ready, arb_request, arb_core_id, perf_grant_count, perf_conflict_count
  );
  modport slave (
    input  l2i_request, l2_stall,
    output l2_ready, arb_request, arb_core_id, perf_grant_count, perf_conflict_count
  );
`else
  modport master (
    output l2i_request, l2_stall,
    input  l2_ready, arb_request, arb_core_id
  );
  modport slave (
    input  l2i_request, l2_stall,
    output l2_ready, arb_request, arb_core_id
  );
`endif

endinterface

`default_nettype wire

// File: rtl/l2_request_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : l2_request_arbiter_rr_arbiter                            |
// | Description : Generic round-robin arbiter. Searches the request mask   |
// |               starting one past the last grant; owns last_grant.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+

module l2_request_arbiter_rr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request_i,
  input  logic                      update_lru_i,
  output logic [NUM_REQUESTERS-1:0] grant_oh_o,
  output logic [ID_WIDTH-1:0]       grant_idx_o
);

  // Pointer starts at the top so requester 0 has first priority after reset.
  localparam logic [ID_WIDTH-1:0] c_last_reset = ID_WIDTH'(NUM_REQUESTERS - 1);

  logic [ID_WIDTH-1:0] last_grant_q;
  logic                found;
  int                  cand;
  logic [ID_WIDTH-1:0] cand_idx;

  // Rotating priority search: first requester after last_grant wins.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQUESTERS) cand = cand - NUM_REQUESTERS;
      cand_idx = ID_WIDTH'(cand);
      if (!found && request_i[cand_idx]) begin
        found                 = 1'b1;
        grant_oh_o[cand_idx]  = 1'b1;
        grant_idx_o           = cand_idx;
      end
    end
  end

  // Remember the winner only when its request was actually accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= c_last_reset;
    end else if (update_lru_i) begin
      last_grant_q <= grant_idx_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_request_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : l2_request_arbiter                                       |
// | Description : Round-robin share of the single L2 request port between  |
// |               the core request interfaces, with a one-entry registered |
// |               output stage that loads while the L2 consumes.           |
// | Options     : define L2_ARB_PERF_COUNTERS_EN for per-requester grant   |
// |               counters and a conflict counter.                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+

module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES,
  parameter int ID_WIDTH       = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  l2_request_arbiter_if.slave  bus
);

  logic [NUM_REQUESTERS-1:0] req_valid;
  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic [ID_WIDTH-1:0]       grant_idx;
  logic                      can_load;
  logic                      any_grant;
  logic                      transfer;

  l2req_packet_t             arb_request_q, arb_request_d;
  logic [ID_WIDTH-1:0]       arb_core_id_q, arb_core_id_d;

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_req_valid
    assign req_valid[g] = bus.l2i_request[g].valid;
  end

  // Output stage is free when empty or when the L2 takes it this cycle.
  assign can_load  = !arb_request_q.valid || !bus.l2_stall;
  assign any_grant = |grant_oh;
  assign transfer  = can_load && any_grant;

  l2_request_arbiter_rr_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .ID_WIDTH       (ID_WIDTH)
  ) u_rr_arbiter (
    .clk          (clk),
    .reset        (reset),
    .request_i    (req_valid),
    .update_lru_i (transfer),
    .grant_oh_o   (grant_oh),
    .grant_idx_o  (grant_idx)
  );

  assign bus.l2_ready    = can_load ? grant_oh : '0;
  assign bus.arb_request = arb_request_q;
  assign bus.arb_core_id = arb_core_id_q;

  // Next output: load the winner, drain to empty, or hold under stall.
  always_comb begin
    arb_request_d = arb_request_q;
    arb_core_id_d = arb_core_id_q;
    if (can_load) begin
      if (any_grant) begin
        arb_request_d = bus.l2i_request[grant_idx];
        arb_core_id_d = grant_idx;
      end else begin
        arb_request_d.valid = 1'b0;
      end
    end
  end

  // One-entry output register; reset discards any in-flight packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_request_q <= '0;
      arb_core_id_q <= '0;
    end else begin
      arb_request_q <= arb_request_d;
      arb_core_id_q <= arb_core_id_d;
    end
  end

`ifdef L2_ARB_PERF_COUNTERS_EN
  logic [NUM_REQUESTERS-1:0][PERF_COUNT_WIDTH-1:0] perf_grant_q;
  logic [PERF_COUNT_WIDTH-1:0]                     perf_conflict_q;

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_perf_grant
    // Count accepted requests per core; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        perf_grant_q[g] <= '0;
      end else if (transfer && grant_oh[g]) begin
        perf_grant_q[g] <= perf_grant_q[g] + 1'b1;
      end
    end
  end

  // Count cycles where a load was possible but several cores competed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflict_q <= '0;
    end else if (can_load && multi_hot(16'(req_valid))) begin
      perf_conflict_q <= perf_conflict_q + 1'b1;
    end
  end

  assign bus.perf_grant_count    = perf_grant_q;
  assign bus.perf_conflict_count = perf_conflict_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_l2_request_arbiter                                    |
// | Description : Directed bench for l2_request_arbiter with 4 requesters, |
// |               a behavioural round-robin model and literal checks.      |
// | Options     : L2_ARB_PERF_COUNTERS_EN enables the counter scenario     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+

module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int N = 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   seq   = 0;

  l2_request_arbiter_if #(.NUM_REQUESTERS(N), .ID_WIDTH(2)) bus ();

  l2_request_arbiter #(.NUM_REQUESTERS(N), .ID_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive all four request slots; fresh contents every call.
  task automatic set_req(input logic [N-1:0] mask);
    l2req_packet_t p;
    for (int i = 0; i < N; i++) begin
      p.valid   = mask[i];
      p.op      = l2_op_t'(2'(i));
      p.address = {8'(i), 24'(seq)};
      p.data    = $urandom;
      bus.l2i_request[i] = p;
    end
    seq++;
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  logic          m_valid;
  l2req_packet_t m_pkt;
  int            m_id;
  int            m_last;
  int            m_grants [N];
  int            m_conf;

  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Compare every cycle on the falling edge, then advance the model.
  always @(negedge clk) begin
    logic [N-1:0] mask;
    logic [N-1:0] exp_ready;
    logic         can;
    int           w;
    int           nvalid;
    if (reset) begin
      m_valid = 1'b0; m_pkt = '0; m_id = 0; m_last = N - 1; m_conf = 0;
      for (int i = 0; i < N; i++) m_grants[i] = 0;
      chk("reset_arb_request", 128'(bus.arb_request), 128'd0);
      chk("reset_core_id", 128'(bus.arb_core_id), 128'd0);
    end else begin
      nvalid = 0;
      for (int i = 0; i < N; i++) begin
        mask[i] = bus.l2i_request[i].valid;
        if (mask[i]) nvalid++;
      end
      can = !m_valid || !bus.l2_stall;
      w   = rr_pick(m_last, mask);
      exp_ready = '0;
      if (can && w >= 0) exp_ready[w] = 1'b1;
      chk("model_ready", 128'(bus.l2_ready), 128'(exp_ready));
      chk("model_valid", 128'(bus.arb_request.valid), 128'(m_valid));
      if (m_valid) begin
        chk("model_core_id", 128'(bus.arb_core_id), 128'(m_id));
        chk("model_packet", 128'(bus.arb_request), 128'(m_pkt));
      end
`ifdef L2_ARB_PERF_COUNTERS_EN
      for (int i = 0; i < N; i++)
        chk("model_grant_count", 128'(bus.perf_grant_count[i]), 128'(m_grants[i]));
      chk("model_conflict_count", 128'(bus.perf_conflict_count), 128'(m_conf));
`endif
      if (can) begin
        if (nvalid >= 2) m_conf++;
        if (w >= 0) begin
          m_pkt = bus.l2i_request[w];
          m_valid = 1'b1; m_id = w; m_last = w;
          m_grants[w]++;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    set_req('0);
    bus.l2_stall = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    l2req_packet_t saved;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [N-1:0] onehot;

    reset = 1'b1;
    bus.l2_stall = 1'b0;
    set_req('0);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("por_arb_request", 128'(bus.arb_request), 128'd0);
    chk("por_core_id", 128'(bus.arb_core_id), 128'd0);

    // Only core 2 valid: accepted same cycle, visible one cycle later.
    cyc(); set_req(4'b0100); #1;
    chk("t1_ready", 128'(bus.l2_ready), 128'b0100);
    saved = bus.l2i_request[2];
    cyc(); set_req(4'b0000); #1;
    chk("t1_valid", 128'(bus.arb_request.valid), 128'd1);
    chk("t1_core_id", 128'(bus.arb_core_id), 128'd2);
    chk("t1_packet", 128'(bus.arb_request), 128'(saved));
    cyc();

    // All cores valid after reset: strict rotation 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(); set_req(4'b1111); #1;
      onehot = '0;
      onehot[order[i]] = 1'b1;
      chk("t2_rotation", 128'(bus.l2_ready), 128'(onehot));
    end

    // Core 1 accepted, then three stalled cycles with core 3 waiting.
    cyc(); set_req(4'b0010); #1;
    chk("t3_ready_core1", 128'(bus.l2_ready), 128'b0010);
    saved = bus.l2i_request[1];
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.l2_stall = 1'b1; set_req(4'b1000); #1;
      chk("t3_stall_ready", 128'(bus.l2_ready), 128'd0);
      chk("t3_stall_id", 128'(bus.arb_core_id), 128'd1);
      chk("t3_stall_packet", 128'(bus.arb_request), 128'(saved));
    end
    cyc(); bus.l2_stall = 1'b0; set_req(4'b1000); #1;
    chk("t3_release_ready", 128'(bus.l2_ready), 128'b1000);

    // Cores 0 and 3 with last grant at 3: 0 wins, then 3.
    cyc(); set_req(4'b1001); #1;
    chk("t3_core3_out", 128'(bus.arb_core_id), 128'd3);
    chk("t4_ready_core0", 128'(bus.l2_ready), 128'b0001);
    cyc(); set_req(4'b1001); #1;
    chk("t4_ready_core3", 128'(bus.l2_ready), 128'b1000);

    // Reset while the output holds a packet: cleared immediately.
    cyc(); reset = 1'b1; set_req(4'b0000); #1;
    chk("t5_reset_clears", 128'(bus.arb_request.valid), 128'd0);
    cyc(); reset = 1'b0; set_req(4'b1010); #1;
    chk("t5_first_grant", 128'(bus.l2_ready), 128'b0010);

    // Lone requester keeps winning every cycle.
    for (int i = 0; i < 3; i++) begin
      cyc(); set_req(4'b1000); #1;
      chk("single_requester", 128'(bus.l2_ready), 128'b1000);
    end

    // Stall is ignored when the output stage is empty.
    cyc(); set_req(4'b0000);
    cyc(); bus.l2_stall = 1'b1; set_req(4'b0100); #1;
    chk("stall_ignored_empty", 128'(bus.l2_ready), 128'b0100);
    cyc(); bus.l2_stall = 1'b0; set_req(4'b0000); #1;
    chk("stall_ignored_id", 128'(bus.arb_core_id), 128'd2);
    chk("stall_ignored_valid", 128'(bus.arb_request.valid), 128'd1);

`ifdef L2_ARB_PERF_COUNTERS_EN
    // 100 cycles of cores 0 and 1 competing.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cyc(); set_req(4'b0011);
    end
    cyc(); set_req(4'b0000); #1;
    chk("perf_grant0", 128'(bus.perf_grant_count[0]), 128'd50);
    chk("perf_grant1", 128'(bus.perf_grant_count[1]), 128'd50);
    chk("perf_grant2", 128'(bus.perf_grant_count[2]), 128'd0);
    chk("perf_grant3", 128'(bus.perf_grant_count[3]), 128'd0);
    chk("perf_conflict", 128'(bus.perf_conflict_count), 128'd100);
`endif

    cyc();
    cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
Shares the single L2 cache request port between the `NUM_CORES` core request interfaces. Each core presents one request packet and holds it until accepted. A round-robin arbiter selects one core per cycle and registers the winning packet into a one-entry output stage feeding the first L2 pipeline stage. Sits between the core array and l2_cache inside gpgpu; it produces the per-core l2_ready signals.

Parameters:
NUM_REQUESTERS, `NUM_CORES, number of request ports (1..16).
ID_WIDTH, $clog2(NUM_REQUESTERS) (minimum 1), width of the source core index.

Ports:
clk  in  1  clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
l2i_request  in  l2req_packet_t[NUM_REQUESTERS]  per-core request; the .valid field is the request strobe.
l2_ready  out  1[NUM_REQUESTERS]  per-core accept; a transfer occurs when valid and ready are both high in the same cycle.
arb_request  out  l2req_packet_t  registered winning packet; .valid is the output-valid flag.
arb_core_id  out  ID_WIDTH  index of the core that issued arb_request.
l2_stall  in  1  L2 pipeline cannot take arb_request this cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - arb_request cleared to all-zero, including .valid = 0.
  - arb_core_id = 0.
  - Priority pointer last_grant = NUM_REQUESTERS-1, so core 0 wins first.
- Output stage can load when: arb_request.valid == 0 OR l2_stall == 0.
- Grant is combinational:
  - Search cores with .valid = 1 starting at last_grant+1 (mod NUM_REQUESTERS).
  - The first one found wins.
  - l2_ready[winner] = 1 only if the output stage can load; all other l2_ready bits = 0.
- On a transfer:
  - Next cycle arb_request = winner packet (valid = 1), arb_core_id = winner, last_grant = winner.
  - Latency is 1 cycle from transfer to arb_request.valid.
- Load possible but no core valid: arb_request.valid clears to 0; last_grant unchanged.
- l2_stall high while valid: arb_request and arb_core_id held bit-stable; all l2_ready = 0.
- l2_stall is ignored while arb_request.valid = 0.
- Throughput: back-to-back transfers every cycle while l2_stall = 0. No bubble on simultaneous consume and load.
- Single requester continuously valid: wins every cycle. Pointer wrap is harmless.
- The arbiter does not require requesters to hold a packet. Deassertion before grant is legal: the request is simply not taken.
- Packet contents are not inspected or modified.
- Reset asserted mid-transfer: the in-flight output is discarded and the core is not re-acknowledged. Cores are reset by the same signal.

Optional Feature:
Macro L2_ARB_PERF_COUNTERS_EN.
- Defined:
  - Per-requester 32-bit grant counters, incremented on each transfer, wrapping at 2^32.
  - One 32-bit conflict counter, incremented in each cycle where a load is possible and ≥2 cores are valid.
  - Extra outputs perf_grant_count[NUM_REQUESTERS] and perf_conflict_count.
  - All counters reset to 0.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- defines.v / shared package: l2req_packet_t, core_id_t (ID_WIDTH), `NUM_CORES.
- Sub-module rr_arbiter:
  - Parameter NUM_REQUESTERS.
  - Inputs: request bitmask, update_lru.
  - Outputs: one-hot grant, grant index.
  - Owns last_grant.
  - Reusable by io_arbiter and the L2 AXI arbitration.

Test Plan (NUM_REQUESTERS=4):
1. After reset, only core 2 valid, l2_stall=0 → l2_ready = 0100 same cycle; next cycle arb_request.valid=1, arb_core_id=2, packet equal to core 2's.
2. All four cores valid every cycle, l2_stall=0 → grant order 0,1,2,3,0,1 on consecutive cycles; each l2_ready one-hot.
3. Core 1 accepted, then l2_stall=1 for 3 cycles with core 3 valid → arb_request held stable for 3 cycles, l2_ready=0000; first cycle after stall drops, core 3 is granted.
4. Cores 0 and 3 valid, last_grant=3 → core 0 wins; next cycle with both still valid, core 3 wins.
5. Reset asserted mid-stream with arb_request.valid=1 → arb_request.valid=0 immediately; first grant after release goes to the lowest-index valid core.
6. With L2_ARB_PERF_COUNTERS_EN, 100 cycles of cores 0 and 1 continuously valid, no stall → grant counts 50/50/0/0, conflict count 100.
